// File: rtl/cache_control_if.sv
// CPU-side and arbiter-side request/response handshake of the L1 cache controller.
// Both sides use level requests held stable until the matching one-cycle response.
interface cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic arb_mem_read;
  logic arb_mem_write;
  logic arb_mem_resp;

  // Controller side: serves the CPU request and issues line transfers to the arbiter.
  modport slave (
    input  mem_read, mem_write, arb_mem_resp,
    output mem_resp, arb_mem_read, arb_mem_write
  );

  // Environment side: CPU plus arbiter.
  modport master (
    output mem_read, mem_write, arb_mem_resp,
    input  mem_resp, arb_mem_read, arb_mem_write
  );
endinterface

// File: rtl/cache_control.sv
// Sequencing FSM for a 2-way set-associative write-back/write-allocate L1 cache datapath,
// with saturating access/miss/writeback counters.
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_control_if.slave       bus,
  input  logic                 hit,
  input  logic                 comp0_out,
  input  logic                 comp1_out,
  input  logic                 vba0_out,
  input  logic                 vba1_out,
  input  logic                 dba0_out,
  input  logic                 dba1_out,
  input  logic                 lru_out,
  input  logic                 clr_counters,
  output logic                 va0_w,
  output logic                 va1_w,
  output logic                 ta0_w,
  output logic                 ta1_w,
  output logic                 da0_w,
  output logic                 da1_w,
  output logic                 dba0_w,
  output logic                 dba1_w,
  output logic                 la_w,
  output logic                 lru_in,
  output logic                 dba_in,
  output logic                 datamux_sel,
  output logic                 dawmux_sel,
  output logic [1:0]           addrmux_sel,
  output logic [CNT_WIDTH-1:0] access_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t state, state_next;
  logic   victim, victim_next;
  logic   inc_access, inc_miss, inc_wb;

  logic req, is_write, whit0, whit1, req_hit;
  logic miss_victim, victim_dirty;

  assign req      = bus.mem_read | bus.mem_write;
  assign is_write = bus.mem_write;
  assign whit0    = vba0_out & comp0_out;
  assign whit1    = vba1_out & comp1_out;
  assign req_hit  = req & hit & (whit0 | whit1);

  // Prefer an invalid way; only fall back to LRU when both ways hold data.
  assign miss_victim  = !vba0_out ? 1'b0 : (!vba1_out ? 1'b1 : lru_out);
  assign victim_dirty = miss_victim ? (vba1_out & dba1_out) : (vba0_out & dba0_out);

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      victim <= 1'b0;
    end else begin
      state  <= state_next;
      victim <= victim_next;
    end
  end

  always_comb begin
    state_next  = state;
    victim_next = victim;
    inc_access  = 1'b0;
    inc_miss    = 1'b0;
    inc_wb      = 1'b0;
    case (state)
      IDLE: begin
        if (req_hit) begin
          inc_access = 1'b1;
        end else if (req) begin
          victim_next = miss_victim;
          inc_miss    = 1'b1;
          state_next  = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        if (bus.arb_mem_resp) begin
          state_next = FILL;
          inc_wb     = 1'b1;
        end
      end
      FILL: begin
        if (bus.arb_mem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced low while rst is high so an aborted transfer drops immediately.
  always_comb begin
    va0_w         = 1'b0;
    va1_w         = 1'b0;
    ta0_w         = 1'b0;
    ta1_w         = 1'b0;
    da0_w         = 1'b0;
    da1_w         = 1'b0;
    dba0_w        = 1'b0;
    dba1_w        = 1'b0;
    la_w          = 1'b0;
    lru_in        = 1'b0;
    dba_in        = 1'b0;
    datamux_sel   = 1'b0;
    dawmux_sel    = 1'b0;
    addrmux_sel   = 2'd0;
    bus.mem_resp      = 1'b0;
    bus.arb_mem_read  = 1'b0;
    bus.arb_mem_write = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_hit) begin
            bus.mem_resp = 1'b1;
            datamux_sel  = whit1;
            la_w         = 1'b1;
            lru_in       = ~whit1;
            if (is_write) begin
              dawmux_sel = 1'b0;
              da0_w      = ~whit1;
              da1_w      = whit1;
              dba0_w     = ~whit1;
              dba1_w     = whit1;
              dba_in     = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          bus.arb_mem_write = 1'b1;
          datamux_sel       = victim;
          addrmux_sel       = victim ? 2'd2 : 2'd1;
        end
        FILL: begin
          bus.arb_mem_read = 1'b1;
          dawmux_sel       = 1'b1;
          if (bus.arb_mem_resp) begin
            da0_w  = ~victim;
            da1_w  = victim;
            ta0_w  = ~victim;
            ta1_w  = victim;
            va0_w  = ~victim;
            va1_w  = victim;
            dba0_w = ~victim;
            dba1_w = victim;
            dba_in = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      access_count <= '0;
      miss_count   <= '0;
      wb_count     <= '0;
    end else if (clr_counters) begin
      access_count <= '0;
      miss_count   <= '0;
      wb_count     <= '0;
    end else begin
      if (inc_access && (access_count != '1)) access_count <= access_count + CNT_WIDTH'(1);
      if (inc_miss && (miss_count != '1))     miss_count   <= miss_count + CNT_WIDTH'(1);
      if (inc_wb && (wb_count != '1))         wb_count     <= wb_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: a transaction-level cache/arbiter model drives the datapath
// status inputs and predicts every control output and counter value.
module tb_cache_control;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_control_if bus ();

  logic hit, comp0_out, comp1_out, vba0_out, vba1_out, dba0_out, dba1_out, lru_out;
  logic clr_counters;
  logic va0_w, va1_w, ta0_w, ta1_w, da0_w, da1_w, dba0_w, dba1_w, la_w;
  logic lru_in, dba_in, datamux_sel, dawmux_sel;
  logic [1:0] addrmux_sel;
  logic [CW-1:0] access_count, miss_count, wb_count;
  logic [1:0] state_dbg;

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hit(hit), .comp0_out(comp0_out), .comp1_out(comp1_out),
    .vba0_out(vba0_out), .vba1_out(vba1_out), .dba0_out(dba0_out), .dba1_out(dba1_out),
    .lru_out(lru_out), .clr_counters(clr_counters),
    .va0_w(va0_w), .va1_w(va1_w), .ta0_w(ta0_w), .ta1_w(ta1_w),
    .da0_w(da0_w), .da1_w(da1_w), .dba0_w(dba0_w), .dba1_w(dba1_w), .la_w(la_w),
    .lru_in(lru_in), .dba_in(dba_in), .datamux_sel(datamux_sel), .dawmux_sel(dawmux_sel),
    .addrmux_sel(addrmux_sel),
    .access_count(access_count), .miss_count(miss_count), .wb_count(wb_count),
    .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic va0_w, va1_w, ta0_w, ta1_w, da0_w, da1_w, dba0_w, dba1_w, la_w;
    logic lru_in, dba_in, datamux_sel, dawmux_sel;
    logic [1:0] addrmux_sel;
    logic mem_resp, arb_read, arb_write;
  } ctl_t;

  ctl_t obs;
  assign obs = {va0_w, va1_w, ta0_w, ta1_w, da0_w, da1_w, dba0_w, dba1_w, la_w,
                lru_in, dba_in, datamux_sel, dawmux_sel, addrmux_sel,
                bus.mem_resp, bus.arb_mem_read, bus.arb_mem_write};

  // Cache contents as the datapath arrays would hold them.
  bit       mvalid [8][2];
  bit       mdirty [8][2];
  bit [8:0] mtag   [8][2];
  bit       mlru   [8];
  logic [15:0] cur_addr;
  logic [2:0]  cs;
  logic [8:0]  ct;
  int m_access, m_miss, m_wb;
  int checks, passes, fails;

  assign cs        = cur_addr[6:4];
  assign ct        = cur_addr[15:7];
  assign vba0_out  = mvalid[cs][0];
  assign vba1_out  = mvalid[cs][1];
  assign comp0_out = (mtag[cs][0] == ct);
  assign comp1_out = (mtag[cs][1] == ct);
  assign dba0_out  = mdirty[cs][0];
  assign dba1_out  = mdirty[cs][1];
  assign lru_out   = mlru[cs];
  assign hit       = (vba0_out & comp0_out) | (vba1_out & comp1_out);

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic int sat(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic counts(input bit clr, input bit ia, input bit im, input bit iw);
    if (clr) begin
      m_access = 0; m_miss = 0; m_wb = 0;
    end else begin
      if (ia) m_access = sat(m_access);
      if (im) m_miss   = sat(m_miss);
      if (iw) m_wb     = sat(m_wb);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_access"}, 32'(access_count), 32'(m_access));
    chk({tag, "_miss"},   32'(miss_count),   32'(m_miss));
    chk({tag, "_wb"},     32'(wb_count),     32'(m_wb));
  endtask

  function automatic int lookup(input logic [2:0] s, input logic [8:0] t);
    if (mvalid[s][0] && mtag[s][0] == t) return 0;
    if (mvalid[s][1] && mtag[s][1] == t) return 1;
    return -1;
  endfunction

  // Request cycle that hits way w; ends just after the completing edge.
  task automatic idle_hit(input string tag, input logic [2:0] s, input bit w, input bit wr, input bit clr);
    ctl_t e;
    e = '0;
    e.mem_resp = 1'b1; e.datamux_sel = w; e.la_w = 1'b1; e.lru_in = !w;
    if (wr) begin
      e.dawmux_sel = 1'b0; e.dba_in = 1'b1;
      if (w) begin e.da1_w = 1'b1; e.dba1_w = 1'b1; end
      else   begin e.da0_w = 1'b1; e.dba0_w = 1'b1; end
    end
    @(negedge clk);
    chk({tag, "_hit"}, 32'(obs), 32'(e));
    @(posedge clk); #1;
    mlru[s] = !w;
    if (wr) mdirty[s][w] = 1'b1;
    counts(clr, 1'b1, 1'b0, 1'b0);
    clr_counters = 1'b0;
  endtask

  // One CPU request from IDLE through any writeback/fill to completion.
  task automatic do_req(input string tag, input logic [15:0] a, input bit wr, input bit both,
                        input bit clr, input bit drop, input int lat_wb, input int lat_fill);
    logic [2:0] s;
    logic [8:0] t;
    int hw;
    bit v;
    ctl_t e;
    s = a[6:4];
    t = a[15:7];
    cur_addr = a;
    bus.mem_write = wr;
    bus.mem_read  = both | !wr;
    clr_counters  = clr;
    hw = lookup(s, t);
    if (hw >= 0) begin
      idle_hit(tag, s, hw[0], wr, clr);
    end else begin
      v = !mvalid[s][0] ? 1'b0 : (!mvalid[s][1] ? 1'b1 : mlru[s]);
      @(negedge clk);
      chk({tag, "_miss_idle"}, 32'(obs), 32'(ctl_t'('0)));
      @(posedge clk); #1;
      counts(clr, 1'b0, 1'b1, 1'b0);
      clr_counters = 1'b0;
      if (drop) begin bus.mem_read = 1'b0; bus.mem_write = 1'b0; end
      if (mvalid[s][v] && mdirty[s][v]) begin
        for (int k = 0; k <= lat_wb; k++) begin
          bus.arb_mem_resp = (k == lat_wb);
          e = '0;
          e.arb_write = 1'b1; e.datamux_sel = v; e.addrmux_sel = v ? 2'd2 : 2'd1;
          @(negedge clk);
          chk({tag, "_wb"}, 32'(obs), 32'(e));
          @(posedge clk); #1;
          bus.arb_mem_resp = 1'b0;
        end
        counts(1'b0, 1'b0, 1'b0, 1'b1);
      end
      for (int k = 0; k <= lat_fill; k++) begin
        bus.arb_mem_resp = (k == lat_fill);
        e = '0;
        e.arb_read = 1'b1; e.dawmux_sel = 1'b1;
        if (k == lat_fill) begin
          if (v) begin e.da1_w = 1'b1; e.ta1_w = 1'b1; e.va1_w = 1'b1; e.dba1_w = 1'b1; end
          else   begin e.da0_w = 1'b1; e.ta0_w = 1'b1; e.va0_w = 1'b1; e.dba0_w = 1'b1; end
        end
        @(negedge clk);
        chk({tag, "_fill"}, 32'(obs), 32'(e));
        @(posedge clk); #1;
        bus.arb_mem_resp = 1'b0;
      end
      mvalid[s][v] = 1'b1;
      mtag[s][v]   = t;
      mdirty[s][v] = 1'b0;
      if (!drop) begin
        idle_hit(tag, s, v, wr, 1'b0);
      end else begin
        @(negedge clk);
        chk({tag, "_dropped_idle"}, 32'(obs), 32'(ctl_t'('0)));
        @(posedge clk); #1;
      end
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    chk_counters(tag);
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0;
    m_access = 0; m_miss = 0; m_wb = 0;
    rst = 1'b1;
    cur_addr = 16'h0000;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.arb_mem_resp = 1'b0;
    clr_counters = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_outputs", 32'(obs), 32'(ctl_t'('0)));
    chk_counters("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold read, way 0 fill, arbiter answers after 3 cycles
    do_req("cold_read", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
    // Write miss fills way 1, then merges as a write hit to way 1
    do_req("write_way1", 16'h52B0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1);
    do_req("read_hit0", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    // LRU names way 1, which is dirty: writeback from way 1 then fill
    do_req("dirty_miss", 16'hD5B0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2);

    // Reset during FILL
    cur_addr = 16'h0450;
    bus.mem_read = 1'b1;
    @(negedge clk);
    chk("rst_fill_miss", 32'(obs), 32'(ctl_t'('0)));
    @(posedge clk); #1;
    counts(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_fill_req", {31'b0, bus.arb_mem_read}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_fill_abort", 32'(obs), 32'(ctl_t'('0)));
    m_access = 0; m_miss = 0; m_wb = 0;
    chk_counters("rst_fill");
    bus.mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.arb_mem_resp = 1'b1;
    @(negedge clk);
    chk("late_resp_idle", 32'(obs), 32'(ctl_t'('0)));
    @(posedge clk); #1;
    bus.arb_mem_resp = 1'b0;
    do_req("refill", 16'h0450, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);

    // Saturate access_count, then clear together with a hit
    for (int i = 0; i < 16; i++) do_req("sat_hit", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    do_req("clr_hit", 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

    // CPU drops request during writeback
    do_req("dirty0", 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    do_req("lru_to0", 16'hD5B0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    do_req("drop_wb", 16'h3BB0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 2);

    // Randomized traffic over a small tag pool so sets see hits, evictions and writebacks
    for (int i = 0; i < 80; i++) begin
      logic [8:0]  rt;
      logic [15:0] ra;
      bit rw, rb, rc, rd;
      case ($urandom_range(0, 4))
        0: rt = 9'h024;
        1: rt = 9'h0A5;
        2: rt = 9'h1AB;
        3: rt = 9'h077;
        default: rt = 9'h100;
      endcase
      ra = {rt, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      rw = ($urandom_range(0, 1) == 1);
      rb = rw && ($urandom_range(0, 4) == 0);
      rc = ($urandom_range(0, 11) == 0);
      rd = ($urandom_range(0, 9) == 0);
      do_req("rand", ra, rw, rb, rc, rd, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        bus.arb_mem_resp = 1'b1;
        @(negedge clk);
        chk("stray_resp", 32'(obs), 32'(ctl_t'('0)));
        @(posedge clk); #1;
        bus.arb_mem_resp = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Sequencing FSM for the 2-way set-associative, write-back, write-allocate L1 cache datapath: 8 sets, 9-bit tags, 128-bit lines.
- Sits between the CPU memory port (mem_read/mem_write/mem_resp) and the arbiter port (arb_mem_read/arb_mem_write/arb_mem_resp).
- Drives every array load strobe and mux select of the datapath; selects victims via per-set LRU bit and dirty bits.
- Keeps saturating hit/miss/writeback counters for performance monitoring.

Parameters:
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
mem_read  in  1  CPU read request, held with address until mem_resp
mem_write  in  1  CPU write request, held with address/data/byte enable until mem_resp
hit, comp0_out, comp1_out, vba0_out, vba1_out, dba0_out, dba1_out, lru_out  in  1 each  datapath status for the indexed set
arb_mem_resp  in  1  arbiter transfer complete, one-cycle pulse
clr_counters  in  1  synchronous clear of performance counters
va0_w, va1_w, ta0_w, ta1_w, da0_w, da1_w, dba0_w, dba1_w, la_w  out  1 each  datapath array load strobes
lru_in, dba_in, datamux_sel, dawmux_sel  out  1 each  datapath data/select controls
addrmux_sel  out  2  0 = CPU address, 1 = way-0 tag writeback address, 2 = way-1 tag writeback address
mem_resp  out  1  CPU request complete
arb_mem_read, arb_mem_write  out  1 each  arbiter line requests
access_count, miss_count, wb_count  out  CNT_WIDTH each  performance counters

Behaviour:
- States: IDLE, WRITEBACK, FILL. Outputs are Moore/Mealy from state plus inputs.
- Unlisted outputs are 0 in every state.
- Reset value: state IDLE, victim register 0, all counters 0, all outputs 0.
- Reset mid-WRITEBACK/FILL aborts immediately: arb requests drop in the reset cycle. Array contents are untouched.
- Request is mem_read | mem_write. If both are asserted, the request is treated as a write.
- Way hit signals: whit0 = vba0_out & comp0_out; whit1 = vba1_out & comp1_out. Hit way w = whit1.
- IDLE, no request: stay in IDLE.
- IDLE, request and hit (combinational response, same cycle):
  - mem_resp=1, datamux_sel=w, la_w=1, lru_in=~w.
  - Write hit additionally: dawmux_sel=0, da{w}_w=1, dba{w}_w=1, dba_in=1.
  - Stay in IDLE. access_count += 1.
- IDLE, request and miss:
  - Victim v = 0 if !vba0_out; else 1 if !vba1_out; else lru_out. Register v.
  - miss_count += 1.
  - Next state WRITEBACK if valid(v) & dirty(v); otherwise FILL.
- WRITEBACK:
  - arb_mem_write=1, datamux_sel=v, addrmux_sel = v ? 2 : 1.
  - Hold until arb_mem_resp, then go to FILL and wb_count += 1.
- FILL:
  - arb_mem_read=1, addrmux_sel=0, dawmux_sel=1.
  - On arb_mem_resp, in the same cycle: da{v}_w=1, ta{v}_w=1, va{v}_w=1, dba{v}_w=1, dba_in=0. Next state IDLE.
  - The re-evaluation in IDLE then hits and completes the request, applying the write merge if it is a write.
- Latency:
  - Hit: 0 extra cycles (mem_resp in the request cycle).
  - Clean miss: arbiter latency + 1.
  - Dirty miss: two arbiter latencies + 1.
- Arbiter handshake:
  - arb_mem_read and arb_mem_write are never both 1.
  - Each is held stable until arb_mem_resp.
  - Once WRITEBACK or FILL is entered, the transfer completes even if the CPU drops its request.
  - arb_mem_resp while in IDLE is ignored.
- mem_resp is never asserted outside IDLE.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_counters has priority over an increment in the same cycle.

Test Plan:
1. Cold read to 0x1234 with both ways invalid, arbiter responding 3 cycles after request -> FILL on way 0, va0_w/ta0_w/da0_w pulse with arb_mem_resp, mem_resp one cycle later, lru_in=1, miss_count=1, access_count=1.
2. Write hit to way 1 with mem_byte_enable=2'b01 -> same-cycle mem_resp, da1_w=dba1_w=1, dba_in=1, dawmux_sel=0, la_w=1 with lru_in=0, no arbiter activity.
3. Both ways valid, lru_out=1, way 1 dirty with tag 0x0A5, miss on set 3 -> WRITEBACK with addrmux_sel=2 (address 0x52B0), then FILL with addrmux_sel=0, wb_count=1, dba1 cleared.
4. Assert rst during FILL two cycles before arb_mem_resp -> arb_mem_read=0 in the same cycle, state IDLE, all counters 0; the late arb_mem_resp causes no array writes.
5. Drive access_count to all-ones with CNT_WIDTH=4 (15 hits), then 1 more hit -> stays 15; clr_counters asserted together with a hit -> 0.
6. CPU drops mem_read during WRITEBACK -> arb_mem_write held until arb_mem_resp, FILL completes, no mem_resp issued.
